softmax_axis_in_16: RTL and testbench

SOFTMAX_AXIS_IN_16 -- requirements
Module: softmax_axis_in_16

---
 rtl/softmax_axis_in_16_pkg.sv | 14 +
 rtl/softmax_axis_in_16_if.sv | 24 ++
 rtl/softmax_axis_in_16.sv | 141 ++++++++++++++
 tb/tb_softmax_axis_in_16.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/softmax_axis_in_16_pkg.sv
// Shared definitions for the softmax input buffer: FSM state encoding,
// FXP 1.7.8 sample width and default packet depth.
package softmax_axis_in_16_pkg;

    localparam int FXP_WIDTH     = 16;
    localparam int DEFAULT_DEPTH = 10;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/softmax_axis_in_16_if.sv
// AXI4-Stream slave bundle feeding the softmax input buffer.
// Signal names match the original flat ports of softmax_axis_in_16.
interface softmax_axis_in_16_if #(
    parameter int DW = 32
);
    logic          s_axis_valid_i;
    logic          s_axis_last_i;
    logic [DW-1:0] s_axis_data_i;
    logic          s_axis_ready_o;

    modport master (
        output s_axis_valid_i,
        output s_axis_last_i,
        output s_axis_data_i,
        input  s_axis_ready_o
    );

    modport slave (
        input  s_axis_valid_i,
        input  s_axis_last_i,
        input  s_axis_data_i,
        output s_axis_ready_o
    );
endinterface

// File: rtl/softmax_axis_in_16.sv
// Softmax input stage: buffers one AXI4-Stream packet, tracks its signed max,
// then replays it to the subtract stage. Optional macro SOFTMAX_AXIS_IN_ROUND_EN.
module softmax_axis_in_16
    import softmax_axis_in_16_pkg::*;
#(
    parameter int data_size = FXP_WIDTH,
    parameter int depth     = DEFAULT_DEPTH
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    softmax_axis_in_16_if.slave  s_axis,
    input  logic                 sub_ready_i,
    output logic [data_size-1:0] data_o,
    output logic                 data_valid_o,
    output logic [data_size-1:0] max_o,
    output logic [7:0]           number_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    localparam int         AW        = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [7:0] DEPTH_CNT = 8'(depth);

    function automatic logic [data_size-1:0] to_sample(input logic [2*data_size-1:0] beat);
        logic [data_size-1:0] hi;
        hi = beat[2*data_size-1:data_size];
`ifdef SOFTMAX_AXIS_IN_ROUND_EN
        // Round half up, saturating at the positive full-scale code.
        if (beat[data_size-1] && (hi == {1'b0, {(data_size-1){1'b1}}}))
            return hi;
        return hi + {{(data_size-1){1'b0}}, beat[data_size-1]};
`else
        return hi;
`endif
    endfunction

    state_e               state_q;
    logic [7:0]           count_q;
    logic [7:0]           rd_q;
    logic                 ready_q;
    logic [data_size-1:0] run_max_q;
    logic [data_size-1:0] max_q;
    logic [7:0]           number_q;
    logic [data_size-1:0] data_q;
    logic                 data_valid_q;
    logic                 done_q;
    logic                 overflow_q;
    logic [data_size-1:0] buf_q [depth];

    logic [data_size-1:0] sample_d;
    logic [data_size-1:0] run_max_d;
    logic [7:0]           count_d;
    logic                 accept;
    logic                 to_drain;

    always_comb begin
        sample_d  = to_sample(s_axis.s_axis_data_i);
        accept    = s_axis.s_axis_valid_i & ready_q;
        count_d   = count_q + 8'd1;
        run_max_d = run_max_q;
        // First beat of a packet seeds the max regardless of the stale value.
        if ((count_q == '0) || ($signed(sample_d) > $signed(run_max_q)))
            run_max_d = sample_d;
        to_drain  = accept & (s_axis.s_axis_last_i | (count_d == DEPTH_CNT));
    end

    always_ff @(posedge clock_i) begin
        if (accept)
            buf_q[AW'(count_q)] <= sample_d;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= RECV;
            count_q      <= '0;
            rd_q         <= '0;
            ready_q      <= 1'b0;
            run_max_q    <= '0;
            max_q        <= '0;
            number_q     <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                RECV: begin
                    data_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                    ready_q      <= ~to_drain;
                    if (accept) begin
                        count_q   <= count_d;
                        run_max_q <= run_max_d;
                    end
                    // max/number are published only here, so they hold through replay.
                    if (to_drain) begin
                        state_q  <= DRAIN;
                        max_q    <= run_max_d;
                        number_q <= count_d;
                        if (!s_axis.s_axis_last_i)
                            overflow_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (sub_ready_i) begin
                        data_q       <= buf_q[AW'(rd_q)];
                        data_valid_q <= 1'b1;
                        rd_q         <= rd_q + 8'd1;
                        if (rd_q == count_q - 8'd1)
                            state_q <= DONE;
                    end else begin
                        data_valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    done_q       <= 1'b1;
                    data_valid_q <= 1'b0;
                    count_q      <= '0;
                    rd_q         <= '0;
                    ready_q      <= 1'b1;
                    state_q      <= RECV;
                end
                default: begin
                    state_q <= RECV;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis.s_axis_ready_o = ready_q;
    assign data_o                = data_q;
    assign data_valid_o          = data_valid_q;
    assign max_o                 = max_q;
    assign number_o              = number_q;
    assign done_o                = done_q;
    assign overflow_o            = overflow_q;

endmodule

// File: tb/tb_softmax_axis_in_16.sv
// Directed, table-driven bench for softmax_axis_in_16 with hand-computed
// expectations; rounding expectations follow SOFTMAX_AXIS_IN_ROUND_EN.
module tb_softmax_axis_in_16;

    logic        clk;
    logic        rst;
    logic        sub_ready;
    logic [15:0] data_o;
    logic        data_valid;
    logic [15:0] max_o;
    logic [7:0]  number_o;
    logic        done_o;
    logic        overflow_o;

    softmax_axis_in_16_if #(.DW(32)) axis ();

    softmax_axis_in_16 #(.data_size(16), .depth(10)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .s_axis       (axis),
        .sub_ready_i  (sub_ready),
        .data_o       (data_o),
        .data_valid_o (data_valid),
        .max_o        (max_o),
        .number_o     (number_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SOFTMAX_AXIS_IN_ROUND_EN
    localparam logic [15:0] RND_A = 16'h0100;
    localparam logic [15:0] RND_B = 16'h0000;
`else
    localparam logic [15:0] RND_A = 16'h00FF;
    localparam logic [15:0] RND_B = 16'hFFFF;
`endif

    typedef struct {
        logic [31:0] beat [4];
        logic [15:0] smp  [4];
        int          n;
        logic [15:0] mx;
    } vec_t;

    vec_t        vt [5];
    logic [15:0] exp_s [16];
    int          vectors;
    int          miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        axis.s_axis_valid_i = 1'b1;
        axis.s_axis_data_i  = d;
        axis.s_axis_last_i  = l;
        n = 0;
        while (axis.s_axis_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("send_ready_timeout", {31'd0, axis.s_axis_ready_o}, 32'd1);
        tick();
        axis.s_axis_valid_i = 1'b0;
        axis.s_axis_last_i  = 1'b0;
    endtask

    // Replays a packet with sub_ready held high and checks order, count and done.
    task automatic drain_check(input string tag, input int n, input logic [15:0] mx);
        int k;
        int got_done;
        k = 0;
        got_done = 0;
        check({tag, "_ready_low"}, {31'd0, axis.s_axis_ready_o}, 32'd0);
        check({tag, "_max"}, {16'd0, max_o}, {16'd0, mx});
        check({tag, "_number"}, {24'd0, number_o}, n);
        sub_ready = 1'b1;
        for (int c = 0; c < 64 && got_done == 0; c++) begin
            tick();
            if (data_valid) begin
                if (k < 16)
                    check({tag, "_data"}, {16'd0, data_o}, {16'd0, exp_s[k]});
                k++;
            end
            if (done_o) begin
                got_done = 1;
                check({tag, "_max_at_done"}, {16'd0, max_o}, {16'd0, mx});
                check({tag, "_number_at_done"}, {24'd0, number_o}, n);
            end
        end
        sub_ready = 1'b0;
        check({tag, "_replayed"}, k, n);
        check({tag, "_done_seen"}, got_done, 1);
        tick();
        check({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, axis.s_axis_ready_o}, 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        vt[0].beat = '{32'h0100_0000, 32'hFF00_0000, 32'h0280_0000, 32'h0};
        vt[0].smp  = '{16'h0100, 16'hFF00, 16'h0280, 16'h0};
        vt[0].n    = 3;
        vt[0].mx   = 16'h0280;
        vt[1].beat = '{32'hFE00_0000, 32'hFF80_0000, 32'h0, 32'h0};
        vt[1].smp  = '{16'hFE00, 16'hFF80, 16'h0, 16'h0};
        vt[1].n    = 2;
        vt[1].mx   = 16'hFF80;
        vt[2].beat = '{32'h8000_0000, 32'h0, 32'h0, 32'h0};
        vt[2].smp  = '{16'h8000, 16'h0, 16'h0, 16'h0};
        vt[2].n    = 1;
        vt[2].mx   = 16'h8000;
        vt[3].beat = '{32'h7FFE_1234, 32'h8000_0000, 32'h0001_7FFF, 32'h7FFF_0000};
        vt[3].smp  = '{16'h7FFE, 16'h8000, 16'h0001, 16'h7FFF};
        vt[3].n    = 4;
        vt[3].mx   = 16'h7FFF;
        vt[4].beat = '{32'h00FF_8000, 32'h7FFF_8000, 32'hFFFF_8000, 32'h0};
        vt[4].smp  = '{RND_A, 16'h7FFF, RND_B, 16'h0};
        vt[4].n    = 3;
        vt[4].mx   = 16'h7FFF;

        rst = 1'b1;
        sub_ready = 1'b0;
        axis.s_axis_valid_i = 1'b0;
        axis.s_axis_last_i  = 1'b0;
        axis.s_axis_data_i  = '0;
        tick();
        tick();
        check("rst_ready", {31'd0, axis.s_axis_ready_o}, 32'd0);
        check("rst_outputs", {data_o, max_o}, 32'd0);
        check("rst_flags", {20'd0, number_o, data_valid, done_o, overflow_o, 1'b0}, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_release", {31'd0, axis.s_axis_ready_o}, 32'd1);

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < vt[v].n; b++) begin
                exp_s[b] = vt[v].smp[b];
                send(vt[v].beat[b], (b == vt[v].n - 1));
            end
            drain_check($sformatf("vec%0d", v), vt[v].n, vt[v].mx);
            check($sformatf("vec%0d_no_overflow", v), {31'd0, overflow_o}, 32'd0);
        end

        // sub_ready toggling during DRAIN: valid follows each high by one cycle.
        exp_s[0] = 16'h0010; exp_s[1] = 16'h0020; exp_s[2] = 16'h0030;
        send(32'h0010_0000, 1'b0);
        send(32'h0020_0000, 1'b0);
        send(32'h0030_0000, 1'b1);
        begin
            int k;
            k = 0;
            for (int i = 0; i < 6; i++) begin
                sub_ready = (i % 2 == 0);
                tick();
                check($sformatf("toggle_valid_%0d", i), {31'd0, data_valid}, (i % 2 == 0) && (i < 5));
                if (data_valid) begin
                    if (k < 3)
                        check($sformatf("toggle_data_%0d", k), {16'd0, data_o}, {16'd0, exp_s[k]});
                    k++;
                end
            end
            check("toggle_count", k, 3);
            check("toggle_done", {31'd0, done_o}, 32'd1);
            sub_ready = 1'b0;
            tick();
        end

        // Overflow: ten beats with no last fill the buffer.
        for (int b = 0; b < 10; b++) begin
            exp_s[b] = 16'(b + 1);
            send({16'(b + 1), 16'h0}, 1'b0);
        end
        check("ovf_flag", {31'd0, overflow_o}, 32'd1);
        drain_check("ovf_pkt", 10, 16'h000A);
        exp_s[0] = 16'h000B; exp_s[1] = 16'h000C;
        send(32'h000B_0000, 1'b0);
        send(32'h000C_0000, 1'b1);
        drain_check("ovf_tail", 2, 16'h000C);
        check("ovf_sticky", {31'd0, overflow_o}, 32'd1);

        // Reset mid-packet discards it.
        send(32'h0040_0000, 1'b0);
        send(32'h0041_0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", {31'd0, axis.s_axis_ready_o}, 32'd0);
        check("midrst_outputs", {data_o, max_o}, 32'd0);
        check("midrst_flags", {20'd0, number_o, data_valid, done_o, overflow_o, 1'b0}, 32'd0);
        tick();
        check("midrst_no_done", {31'd0, done_o}, 32'd0);
        exp_s[0] = 16'h0005; exp_s[1] = 16'h0003;
        send(32'h0005_0000, 1'b0);
        send(32'h0003_0000, 1'b1);
        drain_check("post_rst", 2, 16'h0005);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
